// File: rtl/bit_select_pkg.sv
// bit_select_pkg: shared width default, selector sizing, identity map and occupancy states.
// Rev 1.0
`default_nettype none

package bit_select_pkg;

  localparam int c_DEF_WIDTH = 4;
  localparam int c_MAX_MAP_W = 256;

  function automatic int sel_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Wide enough for any practical WIDTH; callers cast down to their map width.
  function automatic logic [c_MAX_MAP_W-1:0] identity_map(input int w);
    logic [c_MAX_MAP_W-1:0] m;
    m = '0;
    for (int i = 0; i < w; i++) begin
      m = m | (c_MAX_MAP_W'(i) << (i * sel_w(w)));
    end
    return m;
  endfunction

  localparam int c_DEF_MAP_W = c_DEF_WIDTH * sel_w(c_DEF_WIDTH);
  localparam logic [c_DEF_MAP_W-1:0] c_IDENTITY_MAP = c_DEF_MAP_W'(identity_map(c_DEF_WIDTH));

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bit_select_mux.sv
// bit_select_mux: per-lane WIDTH:1 bit select; out-of-range selectors yield 0.
// Rev 1.0
`default_nettype none

module bit_select_mux
  import bit_select_pkg::*;
#(
  parameter  int WIDTH = c_DEF_WIDTH,
  localparam int SEL_W = sel_w(WIDTH)
) (
  input  logic [WIDTH*SEL_W-1:0] sel_map_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [SEL_W-1:0] w_sel;
    assign w_sel     = sel_map_i[i*SEL_W +: SEL_W];
    assign data_o[i] = (int'(w_sel) < WIDTH) ? data_i[w_sel] : 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/bit_select_pipe.sv
// bit_select_pipe: registered programmable bit-select stage with 2-entry skid buffer.
// Rev 1.0 -- optional transfer counter under BIT_SELECT_PIPE_STATS_EN.
`default_nettype none

module bit_select_pipe
  import bit_select_pkg::*;
#(
  parameter int WIDTH = c_DEF_WIDTH
) (
  input  logic                         CLK,
  input  logic                         RESETN,
  input  logic                         cfg_we,
  input  logic [WIDTH*sel_w(WIDTH)-1:0] cfg_map,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         busy
`ifdef BIT_SELECT_PIPE_STATS_EN
  ,
  input  logic                         stats_clr,
  output logic [15:0]                  xfer_count
`endif
);

  localparam int SEL_W = sel_w(WIDTH);
  localparam int MAP_W = WIDTH * SEL_W;
  localparam logic [MAP_W-1:0] c_ID_MAP = MAP_W'(identity_map(WIDTH));

  state_e             state_q, state_d;
  logic [MAP_W-1:0]   map_q, map_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   w_perm;
  logic               w_accept;
  logic               w_emit;

  // Permute with the map as it stands before this edge, so same-cycle map writes apply later.
  bit_select_mux #(.WIDTH(WIDTH)) u_mux (
    .sel_map_i (map_q),
    .data_i    (in_data),
    .data_o    (w_perm)
  );

  always_comb begin
    w_accept = in_valid & in_ready_q;
    w_emit   = out_valid_q & out_ready;
    state_d  = state_q;
    out_d    = out_q;
    skid_d   = skid_q;
    map_d    = cfg_we ? cfg_map : map_q;
    case (state_q)
      EMPTY: begin
        if (w_accept) begin
          out_d   = w_perm;
          state_d = ONE;
        end
      end
      ONE: begin
        if (w_accept && w_emit) begin
          out_d = w_perm;
        end else if (w_accept) begin
          skid_d  = w_perm;
          state_d = TWO;
        end else if (w_emit) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (w_emit) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q     <= EMPTY;
      map_q       <= c_ID_MAP;
      out_q       <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      map_q       <= map_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign busy      = (state_q != EMPTY);

`ifdef BIT_SELECT_PIPE_STATS_EN
  logic [15:0] xfer_count_q;

  // Clear wins over a coincident emit.
  always_ff @(posedge CLK) begin
    if (!RESETN || stats_clr) begin
      xfer_count_q <= 16'd0;
    end else if (w_emit) begin
      xfer_count_q <= xfer_count_q + 16'd1;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bit_select_pipe.sv
// tb_bit_select_pipe: directed self-checking bench for bit_select_pipe (WIDTH=4).
// Rev 1.0
`default_nettype none

module tb_bit_select_pipe;

  logic       CLK;
  logic       RESETN;
  logic       cfg_we;
  logic [7:0] cfg_map;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;
`ifdef BIT_SELECT_PIPE_STATS_EN
  logic        stats_clr;
  logic [15:0] xfer_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bit_select_pipe #(.WIDTH(4)) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .cfg_we    (cfg_we),
    .cfg_map   (cfg_map),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef BIT_SELECT_PIPE_STATS_EN
    ,
    .stats_clr (stats_clr),
    .xfer_count(xfer_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESETN = 1'b0; cfg_we = 1'b0; cfg_map = 8'h00; in_valid = 1'b0;
    in_data = 4'h0; out_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_data !== 4'h0) begin n_err++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
`ifdef BIT_SELECT_PIPE_STATS_EN
    n_cmp++; if (xfer_count !== 16'd0) begin n_err++; $display("FAIL rst_xfer_count got %0d exp 0", xfer_count); end
`endif
    RESETN = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_identity();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'b1010;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL id_out_valid got %b exp 1", out_valid); end
    n_cmp++; if (out_data !== 4'b1010) begin n_err++; $display("FAIL id_out_data got %b exp 1010", out_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL id_drain_valid got %b exp 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL id_drain_busy got %b exp 0", busy); end
  endtask

  task automatic test_map();
    // lane3<-2, lane2<-1, lane1<-0, lane0<-0
    cfg_we = 1'b1; cfg_map = {2'd2, 2'd1, 2'd0, 2'd0};
    tick();
    cfg_we = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'b0110;
    tick();
    n_cmp++; if (out_data !== 4'b1100) begin n_err++; $display("FAIL map_0110 got %b exp 1100", out_data); end
    in_data = 4'b0101;
    tick();
    n_cmp++; if (out_data !== 4'b1011) begin n_err++; $display("FAIL map_0101 got %b exp 1011", out_data); end
    in_valid = 1'b0;
    tick();
    cfg_we = 1'b1; cfg_map = 8'b11_10_01_00;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after_A got %b exp 1", in_ready); end
    in_data = 4'h2;
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_after_B got %b exp 0", in_ready); end
    in_data = 4'h3;
    tick();
    n_cmp++; if (out_data !== 4'h1) begin n_err++; $display("FAIL b2b_hold_A got %h exp 1", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_C_held_off got %b exp 0", in_ready); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_data !== 4'h2 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_B got %h/%b exp 2/1", out_data, out_valid); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 4'h3 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_C got %h/%b exp 3/1", out_data, out_valid); end
    tick();
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got busy %b valid %b exp 0 0", busy, out_valid); end
  endtask

  task automatic test_map_skid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'b0011;
    tick();
    // Map switches to all-lanes-select-3 on the same edge that accepts 1000 into skid.
    in_data = 4'b1000; cfg_we = 1'b1; cfg_map = 8'hFF;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_data !== 4'b0011) begin n_err++; $display("FAIL skid_head got %b exp 0011", out_data); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_data !== 4'b1000) begin n_err++; $display("FAIL skid_old_map got %b exp 1000", out_data); end
    in_valid = 1'b1; in_data = 4'b1000;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 4'b1111) begin n_err++; $display("FAIL skid_new_map got %b exp 1111", out_data); end
    tick();
  endtask

  task automatic test_reset_in_two();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'b1000;
    tick(); tick();
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL r2_setup got ready %b busy %b exp 0 1", in_ready, busy); end
    RESETN = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL r2_flush got valid %b busy %b ready %b exp 0 0 0", out_valid, busy, in_ready);
    end
    RESETN = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL r2_ready got %b exp 1", in_ready); end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'b0101;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 4'b0101) begin n_err++; $display("FAIL r2_identity got %b exp 0101", out_data); end
    tick();
  endtask

`ifdef BIT_SELECT_PIPE_STATS_EN
  task automatic test_stats();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_data = 4'(i); tick(); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (xfer_count !== 16'd3) begin n_err++; $display("FAIL stats_three got %0d exp 3", xfer_count); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    n_cmp++; if (xfer_count !== 16'd0) begin n_err++; $display("FAIL stats_clr_emit got %0d exp 0", xfer_count); end
    in_valid = 1'b1;
    for (int i = 0; i < 65536; i++) tick();
    in_valid = 1'b0;
    n_cmp++; if (xfer_count !== 16'hFFFF) begin n_err++; $display("FAIL stats_ffff got %h exp ffff", xfer_count); end
    tick();
    n_cmp++; if (xfer_count !== 16'd0) begin n_err++; $display("FAIL stats_wrap got %h exp 0", xfer_count); end
  endtask
`endif

  initial begin
`ifdef BIT_SELECT_PIPE_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_identity();
    test_map();
    test_back_to_back();
    test_map_skid();
    test_reset_in_two();
`ifdef BIT_SELECT_PIPE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
